// File: rtl/mem_responder.sv
// Memory-side responder: one single-port 16-bit array shared by backdoor load, data reads,
// write-buffer drain and instruction fetch, with read forwarding from the pending write buffer.
module mem_responder #(
    parameter int AW       = 10,
    parameter int WB_DEPTH = 2
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [15:0]   iAddr,
    input  logic [15:0]   dAddr,
    input  logic          dInCtl,
    input  logic          dOutCtl,
    input  logic [15:0]   dOut,
    input  logic          ldEn,
    input  logic [AW-1:0] ldAddr,
    input  logic [15:0]   ldData,
    output logic [15:0]   dIn,
    output logic          dValid,
    output logic          dInSel,
    output logic          iStall,
    output logic          wbEmpty,
    output logic          wbFull,
    output logic          wrDrop
);

    localparam int         PW      = $clog2(WB_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(WB_DEPTH);

    // Storage without reset: the array and buffer payload are never cleared.
    logic [15:0]   mem [0:(1 << AW) - 1];
    logic [AW-1:0] wb_addr [WB_DEPTH];
    logic [15:0]   wb_data [WB_DEPTH];
    logic [15:0]   ram_q;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_next;

    logic          fwd_q;
    logic [15:0]   fwd_data_q;
    logic          out_live;

    logic          rd_grant;
    logic          drain_grant;
    logic          fetch_grant;
    logic          serve;
    logic          buf_nonempty;
    logic          buf_full;
    logic          enq;
    logic          drop;
    logic [AW-1:0] rd_addr;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;

    logic [WB_DEPTH-1:0] hit;
    logic [15:0]         age_word [WB_DEPTH];
    logic                fwd_hit;
    logic [15:0]         fwd_data;

    generate
        if (AW < 16) begin : g_unused
            logic unused_addr_bits;
            assign unused_addr_bits = ^{iAddr[15:AW], dAddr[15:AW]};
        end
    endgenerate

    // Fixed port priority: load, data read, drain, fetch.
    assign buf_nonempty = (count != '0);
    assign buf_full     = (count == DEPTH_C);
    assign rd_grant     = dInCtl & ~ldEn;
    assign drain_grant  = ~ldEn & ~dInCtl & buf_nonempty;
    assign fetch_grant  = ~ldEn & ~dInCtl & ~buf_nonempty;
    assign serve        = rd_grant | fetch_grant;
    assign rd_addr      = rd_grant ? dAddr[AW-1:0] : iAddr[AW-1:0];

    assign enq  = dOutCtl & (~buf_full | drain_grant);
    assign drop = dOutCtl & ~enq;
    assign count_next = count + {{PW{1'b0}}, enq} - {{PW{1'b0}}, drain_grant};

    assign mem_we    = ldEn | drain_grant;
    assign mem_waddr = ldEn ? ldAddr : wb_addr[rd_ptr];
    assign mem_wdata = ldEn ? ldData : wb_data[rd_ptr];

    // Entry gi is the gi-th oldest pending write; only occupied ages may match.
    generate
        for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_age
            logic [PW-1:0] slot;
            assign slot         = rd_ptr + PW'(gi);
            assign hit[gi]      = ((PW + 1)'(gi) < count) && (wb_addr[slot] == rd_addr);
            assign age_word[gi] = wb_data[slot];
        end
    endgenerate

    // Later (younger) matches override earlier ones.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (hit[k]) begin
                fwd_hit  = 1'b1;
                fwd_data = age_word[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (serve) begin
            ram_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            wb_addr[wr_ptr] <= dAddr[AW-1:0];
            wb_data[wr_ptr] <= dOut;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dValid     <= 1'b0;
            dInSel     <= 1'b0;
            iStall     <= 1'b0;
            wbEmpty    <= 1'b1;
            wbFull     <= 1'b0;
            wrDrop     <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            out_live   <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (drain_grant) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count   <= count_next;
            dValid  <= serve;
            iStall  <= ~fetch_grant;
            wbEmpty <= (count_next == '0);
            wbFull  <= (count_next == DEPTH_C);
            wrDrop  <= drop;
            if (serve) begin
                dInSel     <= rd_grant;
                fwd_q      <= fwd_hit;
                fwd_data_q <= fwd_data;
                out_live   <= 1'b1;
            end
        end
    end

    // dIn selects between two registered sources with a registered select, so it changes only
    // at the clock edge; out_live forces zero until the first word after reset.
    assign dIn = !out_live ? 16'h0000 : (fwd_q ? fwd_data_q : ram_q);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: stimulus rows push expected responses into a queue and a
// separate monitor pops one entry after each clock edge and compares the DUT outputs.
module tb_mem_responder;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          nreset = 1'b1;
    logic [15:0]   iAddr = '0;
    logic [15:0]   dAddr = '0;
    logic          dInCtl = 1'b0;
    logic          dOutCtl = 1'b0;
    logic [15:0]   dOut = '0;
    logic          ldEn = 1'b0;
    logic [AW-1:0] ldAddr = '0;
    logic [15:0]   ldData = '0;
    logic [15:0]   dIn;
    logic          dValid;
    logic          dInSel;
    logic          iStall;
    logic          wbEmpty;
    logic          wbFull;
    logic          wrDrop;

    typedef struct {
        int          id;
        logic        valid;
        logic        sel;
        logic        chk;
        logic [15:0] data;
        logic        stall;
        logic        empty;
        logic        full;
        logic        drop;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   row = 0;

    mem_responder #(.AW(AW), .WB_DEPTH(2)) dut (
        .clk(clk), .nreset(nreset), .iAddr(iAddr), .dAddr(dAddr), .dInCtl(dInCtl),
        .dOutCtl(dOutCtl), .dOut(dOut), .ldEn(ldEn), .ldAddr(ldAddr), .ldData(ldData),
        .dIn(dIn), .dValid(dValid), .dInSel(dInSel), .iStall(iStall), .wbEmpty(wbEmpty),
        .wbFull(wbFull), .wrDrop(wrDrop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " dIn"}, dIn, 16'h0000);
        check({tag, " dValid"}, {15'd0, dValid}, 16'd0);
        check({tag, " dInSel"}, {15'd0, dInSel}, 16'd0);
        check({tag, " iStall"}, {15'd0, iStall}, 16'd0);
        check({tag, " wbEmpty"}, {15'd0, wbEmpty}, 16'd1);
        check({tag, " wbFull"}, {15'd0, wbFull}, 16'd0);
        check({tag, " wrDrop"}, {15'd0, wrDrop}, 16'd0);
    endtask

    // One bus cycle: drive inputs on the falling edge and queue the response expected after
    // the next rising edge.
    task automatic cyc(input int ld, input int la, input int ldat, input int rd, input int wr,
                       input int da, input int wd, input int ia,
                       input int v, input int s, input int c, input int d,
                       input int st, input int em, input int fu, input int dr);
        exp_t e;
        @(negedge clk);
        ldEn    = (ld != 0);
        ldAddr  = la[AW-1:0];
        ldData  = ldat[15:0];
        dInCtl  = (rd != 0);
        dOutCtl = (wr != 0);
        dAddr   = da[15:0];
        dOut    = wd[15:0];
        iAddr   = ia[15:0];
        e.id    = row;
        e.valid = (v != 0);
        e.sel   = (s != 0);
        e.chk   = (c != 0);
        e.data  = d[15:0];
        e.stall = (st != 0);
        e.empty = (em != 0);
        e.full  = (fu != 0);
        e.drop  = (dr != 0);
        exp_q.push_back(e);
        row++;
    endtask

    task automatic idle_inputs();
        ldEn = 1'b0; dInCtl = 1'b0; dOutCtl = 1'b0;
        dAddr = '0; dOut = '0; iAddr = '0; ldAddr = '0; ldData = '0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (nreset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("row %0d: dIn=%h dValid=%b dInSel=%b iStall=%b wbEmpty=%b wbFull=%b wrDrop=%b",
                         e.id, dIn, dValid, dInSel, iStall, wbEmpty, wbFull, wrDrop);
                check($sformatf("row%0d dValid", e.id), {15'd0, dValid}, {15'd0, e.valid});
                check($sformatf("row%0d iStall", e.id), {15'd0, iStall}, {15'd0, e.stall});
                check($sformatf("row%0d wbEmpty", e.id), {15'd0, wbEmpty}, {15'd0, e.empty});
                check($sformatf("row%0d wbFull", e.id), {15'd0, wbFull}, {15'd0, e.full});
                check($sformatf("row%0d wrDrop", e.id), {15'd0, wrDrop}, {15'd0, e.drop});
                if (e.chk) begin
                    check($sformatf("row%0d dIn", e.id), dIn, e.data);
                    if (e.valid) begin
                        check($sformatf("row%0d dInSel", e.id), {15'd0, dInSel}, {15'd0, e.sel});
                    end
                end
            end
        end
    end

    initial begin : stimulus
        #1 nreset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset("por");
        @(negedge clk);
        nreset = 1'b1;

        //   ld la  ldat     rd wr da  wd       ia   v s c data     st em fu dr
        // backdoor load; a data read loses to ldEn
        cyc(1, 5,  'h1234,  0, 0, 0,  0,       0,   0,0,0,0,       1, 1, 0, 0);
        cyc(1, 6,  'hBEEF,  0, 0, 0,  0,       0,   0,0,0,0,       1, 1, 0, 0);
        cyc(1, 3,  'h3333,  1, 0, 6,  0,       0,   0,0,0,0,       1, 1, 0, 0);
        cyc(1, 31, 'h3131,  0, 0, 0,  0,       0,   0,0,0,0,       1, 1, 0, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       5,   1,0,1,'h1234,  0, 1, 0, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       6,   1,0,1,'hBEEF,  0, 1, 0, 0);
        // write then forwarded read, drain, fetch back from array
        cyc(0, 0,  0,       0, 1, 9,  'hA5A5,  5,   1,0,1,'h1234,  0, 0, 0, 0);
        cyc(0, 0,  0,       1, 0, 9,  0,       5,   1,1,1,'hA5A5,  1, 0, 0, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       5,   0,0,1,'hA5A5,  1, 1, 0, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       9,   1,0,1,'hA5A5,  0, 1, 0, 0);
        // same-cycle write invisible; youngest pending entry wins
        cyc(0, 0,  0,       1, 1, 3,  'h0001,  0,   1,1,1,'h3333,  1, 0, 0, 0);
        cyc(0, 0,  0,       1, 1, 3,  'h0002,  0,   1,1,1,'h0001,  1, 0, 1, 0);
        cyc(0, 0,  0,       1, 0, 3,  0,       0,   1,1,1,'h0002,  1, 0, 1, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       3,   0,0,0,0,       1, 0, 0, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       3,   0,0,0,0,       1, 1, 0, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       3,   1,0,1,'h0002,  0, 1, 0, 0);
        // read+write every cycle: no drain, third and fourth writes dropped
        cyc(0, 0,  0,       1, 1, 5,  'h1111,  0,   1,1,1,'h1234,  1, 0, 0, 0);
        cyc(0, 0,  0,       1, 1, 6,  'h2222,  0,   1,1,1,'hBEEF,  1, 0, 1, 0);
        cyc(0, 0,  0,       1, 1, 9,  'h3333,  0,   1,1,1,'hA5A5,  1, 0, 1, 1);
        cyc(0, 0,  0,       1, 1, 3,  'h4444,  0,   1,1,1,'h0002,  1, 0, 1, 1);
        cyc(0, 0,  0,       0, 0, 0,  0,       0,   0,0,0,0,       1, 0, 0, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       0,   0,0,0,0,       1, 1, 0, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       5,   1,0,1,'h1111,  0, 1, 0, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       6,   1,0,1,'h2222,  0, 1, 0, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       9,   1,0,1,'hA5A5,  0, 1, 0, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       3,   1,0,1,'h0002,  0, 1, 0, 0);
        // enqueue while full is accepted when a drain happens in the same cycle
        cyc(0, 0,  0,       0, 1, 30, 'hAAAA,  5,   1,0,1,'h1111,  0, 0, 0, 0);
        cyc(0, 0,  0,       1, 1, 31, 'hBBBB,  0,   1,1,1,'h3131,  1, 0, 1, 0);
        cyc(0, 0,  0,       0, 1, 32, 'hCCCC,  0,   0,0,0,0,       1, 0, 1, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       0,   0,0,0,0,       1, 0, 0, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       0,   0,0,0,0,       1, 1, 0, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       30,  1,0,1,'hAAAA,  0, 1, 0, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       31,  1,0,1,'hBBBB,  0, 1, 0, 0);
        cyc(0, 0,  0,       0, 0, 0,  0,       32,  1,0,1,'hCCCC,  0, 1, 0, 0);
        // two entries pending plus a forwarded read, then reset mid-operation
        cyc(0, 0,  0,       1, 1, 5,  'h7777,  0,   1,1,1,'h1111,  1, 0, 0, 0);
        cyc(0, 0,  0,       1, 1, 6,  'h8888,  0,   1,1,1,'h2222,  1, 0, 1, 0);
        cyc(0, 0,  0,       1, 0, 5,  0,       0,   1,1,1,'h7777,  1, 0, 1, 0);
        @(posedge clk);
        #3;
        nreset = 1'b0;
        idle_inputs();
        #1 check_reset("midrst");
        repeat (2) @(posedge clk);
        #1 check_reset("midrst_hold");
        @(negedge clk);
        nreset = 1'b1;
        cyc(0, 0,  0,       1, 0, 5,  0,       0,   1,1,1,'h1111,  1, 1, 0, 0);
        cyc(0, 0,  0,       1, 0, 6,  0,       0,   1,1,1,'h2222,  1, 1, 0, 0);
        @(negedge clk);
        idle_inputs();
        repeat (2) @(posedge clk);
        #3;
        check("scoreboard drained", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the SimpleCore instruction/data bus. It serves instruction fetches and data reads from a single-port 16-bit word array, and posts data writes into a small write buffer that drains into the array when the port is free. Reads that hit a pending write are forwarded from the buffer. It returns one registered word per cycle on `dIn`, which is the core's shared instruction/data input.

## Interface
Parameters:
- `AW`, default 10: word-address width; the array holds 2^AW x 16 bits.
- `WB_DEPTH`, default 2: write-buffer entries; power of two, at least 2.

Ports:
- `clk`  in  1  main clock; all state updates on the rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `iAddr`  in  16  instruction fetch address; bits [AW-1:0] used, upper bits ignored.
- `dAddr`  in  16  data address for reads and writes; bits [AW-1:0] used.
- `dInCtl`  in  1  data read request this cycle.
- `dOutCtl`  in  1  data write request this cycle.
- `dOut`  in  16  write data; sampled when `dOutCtl`=1.
- `ldEn`  in  1  backdoor array write, used for program load.
- `ldAddr`  in  AW  backdoor address.
- `ldData`  in  16  backdoor data.
- `dIn`  out  16  registered read word returned to the core.
- `dValid`  out  1  `dIn` holds the word requested in the previous cycle.
- `dInSel`  out  1  1: `dIn` is a data word; 0: `dIn` is an instruction.
- `iStall`  out  1  previous-cycle fetch was not served; the core must re-present `iAddr`.
- `wbEmpty`  out  1  write buffer holds no entries.
- `wbFull`  out  1  write buffer holds `WB_DEPTH` entries.
- `wrDrop`  out  1  one-cycle pulse: the previous-cycle write was discarded.

## Operation
- Single array port; exactly one array operation per cycle, granted in this fixed priority:
  1. backdoor write (`ldEn`);
  2. data read (`dInCtl`);
  3. buffer drain (oldest entry written to the array; requires the buffer to be non-empty);
  4. instruction fetch.
- A fetch is requested every cycle. It is served only when no higher-priority operation wins the port. If it is not served, `iStall`=1 next cycle.
- Data read that is not served (because `ldEn` wins): `dValid`=0 next cycle, with no other indication.
- Write buffer: circular FIFO of {addr[AW-1:0], data[15:0]} with read and write pointers plus an occupancy counter of width log2(`WB_DEPTH`)+1.
- Enqueue on `dOutCtl` is independent of the port grant.
- Enqueue when full is accepted only if a drain happens in the same cycle; otherwise the write is dropped and `wrDrop` pulses the next cycle.
- Enqueue and drain in the same cycle leave occupancy unchanged.
- Forwarding applies to both data reads and fetches:
  - The buffer is searched using its contents before this cycle's enqueue.
  - The youngest matching entry supplies the data; the array value is ignored.
  - A write in the same cycle to the same address is not visible; the read returns the older value.
- Backdoor writes go directly to the array. A pending buffer entry to the same address later overwrites the array. A forwarded read returns the buffer value. Loading while the buffer is non-empty is a software error and is not checked.
- Pointers wrap modulo `WB_DEPTH`.
- Array contents are not reset.

## Timing
- Read latency is 1 cycle: a request in cycle N produces `dIn`, `dValid`, and `dInSel` after edge N+1. This holds for both array reads and forwarded reads.
- Every output is registered.
- Reset values: `dIn`=0, `dValid`=0, `dInSel`=0, `iStall`=0, `wbEmpty`=1, `wbFull`=0, `wrDrop`=0; buffer pointers and counter are 0.
- When neither a read nor a fetch is served, `dIn` holds its previous value.
- `wbFull` and `wbEmpty` reflect occupancy after the edge.
- Reset asserted mid-operation:
  - Buffered writes are lost, and no partial drain occurs.
  - Any read in flight is discarded (`dValid`=0).
- After `nreset` deasserts, the first fetch is served in the first cycle with no other array user.

## Test plan
- Backdoor-load 0x1234 at 5, 0xBEEF at 6, then fetch `iAddr`=5 then 6 -> `dIn`=0x1234 and then 0xBEEF; `dValid`=1, `dInSel`=0, `iStall`=0.
- Write 0xA5A5 to `dAddr`=9, then read 9 on the next cycle (before drain) -> `dIn`=0xA5A5, `dInSel`=1. Buffer drains the cycle after; `wbEmpty`=1 one edge later.
- Two writes (3<-0x0001, then 3<-0x0002) followed by a read of 3 -> forwarded value 0x0002 (youngest).
- `dOutCtl` and `dInCtl` held high for 4 cycles on distinct addresses with `WB_DEPTH`=2, so no drain is possible -> third write gives `wrDrop`=1, `wbFull`=1; `dIn` returns array data each cycle.
- Buffer non-empty and fetch requested -> drain wins, `iStall`=1 for exactly one cycle per drained entry; afterwards the array holds the written values.
- Assert `nreset` with 2 entries pending and a read in flight -> all outputs at reset values immediately; after release, a read of those addresses returns the old array contents.
